// File: rtl/keycode_motion_ctrl_if.sv
// Keycode motion controller bus.
// Carries the frame strobe, keycode and collision flag into the controller,
// and the sprite position and status back out to the sprite/collision logic.
//   frame_clk : vsync-rate strobe, asynchronous to the system clock
//   keycode   : 8-bit arrow keycode (0x4F R, 0x50 L, 0x51 D, 0x52 U)
//   collision : sprite overlap flag, sampled at frame tick
//   pos_x/y   : 10-bit sprite position
//   dir       : last direction (00 R, 01 L, 10 D, 11 U)
//   moving    : controller in MOVE
//   blocked   : controller in BLOCKED
//   edge_hit  : one-clock pulse when a bound clamp shortened a step
interface keycode_motion_ctrl_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       collision;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] dir;
    logic       moving;
    logic       blocked;
    logic       edge_hit;

    // master: keyboard/sequencer side, drives keys and reads the position
    modport master (
        output frame_clk, keycode, collision,
        input  pos_x, pos_y, dir, moving, blocked, edge_hit
    );

    // slave: the motion controller
    modport slave (
        input  frame_clk, keycode, collision,
        output pos_x, pos_y, dir, moving, blocked, edge_hit
    );
endinterface

// File: rtl/keycode_motion_ctrl.sv
// Keycode motion controller.
// Turns arrow-key keycodes into per-frame sprite motion with bound clamping
// and a collision back-off that suppresses motion for HOLD_FRAMES ticks.
// Ports:
//   Clk     : system clock
//   Reset_n : asynchronous active-low reset
//   bus     : keycode_motion_ctrl_if.slave (frame_clk, keycode, collision in;
//             pos_x, pos_y, dir, moving, blocked, edge_hit out)
module keycode_motion_ctrl #(
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 639,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned X_START     = 320,
    parameter int unsigned Y_START     = 240,
    parameter int unsigned STEP        = 2,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    keycode_motion_ctrl_if.slave  bus
);

    localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] Y_MIN_W   = 11'(Y_MIN);
    localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [9:0]  X_START_W = 10'(X_START);
    localparam logic [9:0]  Y_START_W = 10'(Y_START);
    localparam logic [7:0]  HOLD_W    = 8'(HOLD_FRAMES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE    = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t     state;
    logic [9:0] pos_x, pos_y;
    logic [9:0] prev_x, prev_y;
    logic [1:0] dir;
    logic [7:0] hold_cnt;
    logic       edge_hit;
    logic [7:0] key_q;

    // [0],[1]: synchronizer; [2]: previous synchronized level for edge detect
    logic [2:0] fsync;
    logic       tick;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync <= 3'b000;
            key_q <= 8'h00;
        end else begin
            fsync <= {fsync[1:0], bus.frame_clk};
            key_q <= bus.keycode;
        end
    end

    // One-clock pulse on the synchronized rising edge; a long level gives one tick.
    assign tick = fsync[1] & ~fsync[2];

    // Key decode and clamped step for the selected axis.
    logic        key_valid;
    logic [1:0]  key_dir;
    logic [10:0] cur, lim_hi, lim_lo, sum;
    logic [9:0]  nxt;
    logic        clamp;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'b00;
        case (key_q)
            8'h4F:   key_dir = 2'b00;
            8'h50:   key_dir = 2'b01;
            8'h51:   key_dir = 2'b10;
            8'h52:   key_dir = 2'b11;
            default: key_valid = 1'b0;
        endcase

        // dir[1] selects the y axis; dir[0] set means a decrement (left/up)
        cur    = key_dir[1] ? {1'b0, pos_y} : {1'b0, pos_x};
        lim_hi = key_dir[1] ? Y_MAX_W : X_MAX_W;
        lim_lo = key_dir[1] ? Y_MIN_W : X_MIN_W;
        sum    = cur + STEP_W;
        clamp  = 1'b0;
        nxt    = 10'(cur);

        if (!key_dir[0]) begin
            if (sum > lim_hi) begin
                nxt   = 10'(lim_hi);
                clamp = 1'b1;
            end else begin
                nxt = 10'(sum);
            end
        end else begin
            // compare before subtracting so the 11-bit value never wraps
            if (cur < lim_lo + STEP_W) begin
                nxt   = 10'(lim_lo);
                clamp = 1'b1;
            end else begin
                nxt = 10'(cur - STEP_W);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            pos_x    <= X_START_W;
            pos_y    <= Y_START_W;
            prev_x   <= X_START_W;
            prev_y   <= Y_START_W;
            dir      <= 2'b00;
            hold_cnt <= 8'd0;
            edge_hit <= 1'b0;
        end else begin
            edge_hit <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE, MOVE: begin
                        if (bus.collision) begin
                            // back off to the last position; prev stays so a
                            // repeated collision cannot walk further back
                            pos_x    <= prev_x;
                            pos_y    <= prev_y;
                            hold_cnt <= HOLD_W;
                            state    <= BLOCKED;
                        end else if (key_valid) begin
                            prev_x <= pos_x;
                            prev_y <= pos_y;
                            if (key_dir[1]) pos_y <= nxt;
                            else            pos_x <= nxt;
                            dir      <= key_dir;
                            edge_hit <= clamp;
                            state    <= MOVE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    BLOCKED: begin
                        if (bus.collision) begin
                            hold_cnt <= HOLD_W;
                        end else if (hold_cnt <= 8'd1) begin
                            hold_cnt <= 8'd0;
                            state    <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pos_x    = pos_x;
    assign bus.pos_y    = pos_y;
    assign bus.dir      = dir;
    assign bus.edge_hit = edge_hit;
    assign bus.moving   = (state == MOVE);
    assign bus.blocked  = (state == BLOCKED);

endmodule

// File: tb/tb_keycode_motion_ctrl.sv
// Directed bench for keycode_motion_ctrl with hand-computed expectations.
module tb_keycode_motion_ctrl;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic clk_en = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    keycode_motion_ctrl_if bus ();

    keycode_motion_ctrl dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    // gated clock so the reset can be exercised with the clock stopped
    always begin
        #5;
        if (clk_en) Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // One-clock frame_clk pulse; returns at the negedge after the update edge.
    // With chk_lat set, verifies that nothing moved one clock earlier.
    task automatic frame_pulse(input bit chk_lat, input logic [9:0] old_x);
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        @(negedge Clk);            // after edge k (first sample)
        bus.frame_clk = 1'b0;
        @(negedge Clk);            // after edge k+1
        if (chk_lat) chk("latency_hold", 32'(bus.pos_x), 32'(old_x));
        @(negedge Clk);            // after edge k+2: updated
    endtask

    initial begin
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        bus.collision = 1'b0;

        // reset state
        do_reset();
        chk("rst_x", 32'(bus.pos_x), 320);
        chk("rst_y", 32'(bus.pos_y), 240);
        chk("rst_dir", 32'(bus.dir), 0);
        chk("rst_moving", 32'(bus.moving), 0);
        chk("rst_blocked", 32'(bus.blocked), 0);
        chk("rst_edge", 32'(bus.edge_hit), 0);

        // 1: three right ticks with latency check
        bus.keycode = 8'h4F;
        for (int i = 0; i < 3; i++) begin
            frame_pulse(1'b1, 10'(320 + 2 * i));
            chk("t1_x", 32'(bus.pos_x), 32'(322 + 2 * i));
        end
        chk("t1_y", 32'(bus.pos_y), 240);
        chk("t1_dir", 32'(bus.dir), 0);
        chk("t1_moving", 32'(bus.moving), 1);

        // 2: run into the right bound
        do_reset();
        bus.keycode = 8'h4F;
        for (int i = 0; i < 159; i++) frame_pulse(1'b0, 10'd0);
        chk("t2_x159", 32'(bus.pos_x), 638);
        chk("t2_edge159", 32'(bus.edge_hit), 0);
        frame_pulse(1'b0, 10'd0);
        chk("t2_x160", 32'(bus.pos_x), 639);
        chk("t2_edge160", 32'(bus.edge_hit), 1);
        @(negedge Clk);
        chk("t2_edge_clr", 32'(bus.edge_hit), 0);
        frame_pulse(1'b0, 10'd0);
        chk("t2_x161", 32'(bus.pos_x), 639);
        chk("t2_edge161", 32'(bus.edge_hit), 1);

        // 3: collision back-off and hold-off
        do_reset();
        bus.keycode = 8'h4F;
        frame_pulse(1'b0, 10'd0);
        frame_pulse(1'b0, 10'd0);
        chk("t3_x324", 32'(bus.pos_x), 324);
        bus.collision = 1'b1;
        frame_pulse(1'b0, 10'd0);
        bus.collision = 1'b0;
        chk("t3_revert", 32'(bus.pos_x), 322);
        chk("t3_blocked", 32'(bus.blocked), 1);
        chk("t3_revert_edge", 32'(bus.edge_hit), 0);
        bus.keycode = 8'h52;
        for (int i = 0; i < 4; i++) begin
            frame_pulse(1'b0, 10'd0);
            chk("t3_hold_x", 32'(bus.pos_x), 322);
            chk("t3_hold_y", 32'(bus.pos_y), 240);
            chk("t3_hold_blk", 32'(bus.blocked), (i < 3) ? 1 : 0);
        end
        chk("t3_idle_mv", 32'(bus.moving), 0);
        frame_pulse(1'b0, 10'd0);
        chk("t3_up_y", 32'(bus.pos_y), 238);
        chk("t3_up_dir", 32'(bus.dir), 3);
        chk("t3_up_x", 32'(bus.pos_x), 322);

        // 4: left then stop
        do_reset();
        bus.keycode = 8'h50;
        frame_pulse(1'b0, 10'd0);
        chk("t4_x318", 32'(bus.pos_x), 318);
        chk("t4_dir", 32'(bus.dir), 1);
        bus.keycode = 8'h00;
        frame_pulse(1'b0, 10'd0);
        chk("t4_stop_x", 32'(bus.pos_x), 318);
        chk("t4_stop_mv", 32'(bus.moving), 0);
        chk("t4_stop_dir", 32'(bus.dir), 1);

        // 5: async reset while BLOCKED with the clock stopped
        do_reset();
        bus.keycode = 8'h51;
        frame_pulse(1'b0, 10'd0);          // y=242, dir=10
        bus.keycode = 8'h4F;
        frame_pulse(1'b0, 10'd0);          // x=322
        frame_pulse(1'b0, 10'd0);          // x=324
        bus.collision = 1'b1;
        frame_pulse(1'b0, 10'd0);          // back to x=322, y=242
        bus.collision = 1'b0;
        chk("t5_pre_blk", 32'(bus.blocked), 1);
        chk("t5_pre_y", 32'(bus.pos_y), 242);
        clk_en = 1'b0;
        #20;
        Reset_n = 1'b0;
        #3;
        chk("t5_rst_x", 32'(bus.pos_x), 320);
        chk("t5_rst_y", 32'(bus.pos_y), 240);
        chk("t5_rst_dir", 32'(bus.dir), 0);
        chk("t5_rst_blk", 32'(bus.blocked), 0);
        chk("t5_rst_mv", 32'(bus.moving), 0);
        #7;
        Reset_n = 1'b1;
        clk_en = 1'b1;
        repeat (2) @(negedge Clk);
        bus.keycode = 8'h51;
        frame_pulse(1'b0, 10'd0);
        chk("t5_down_y", 32'(bus.pos_y), 242);
        chk("t5_down_x", 32'(bus.pos_x), 320);

        // 6: long frame_clk level gives a single update; then a 1-clock pulse
        do_reset();
        bus.keycode = 8'h4F;
        @(negedge Clk);
        bus.frame_clk = 1'b1;
        repeat (50) @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        chk("t6_long_x", 32'(bus.pos_x), 322);
        frame_pulse(1'b0, 10'd0);
        repeat (3) @(negedge Clk);
        chk("t6_pulse_x", 32'(bus.pos_x), 324);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/keycode_motion_ctrl.md
Name: keycode_motion_ctrl

Overview:
Receiving end of the keycode stream that the scripted enemy sequencer and the keyboard path produce. Decodes 8-bit arrow-key keycodes into per-frame sprite motion. Produces the sprite position consumed by the sprite/collision logic. Includes bound clamping and a collision back-off with a hold-off period.

Parameters:
X_MIN, 0, leftmost legal pos_x
X_MAX, 639, rightmost legal pos_x
Y_MIN, 0, topmost legal pos_y
Y_MAX, 479, bottommost legal pos_y
X_START, 320, pos_x after reset
Y_START, 240, pos_y after reset
STEP, 2, pixels moved per frame tick (1..15)
HOLD_FRAMES, 4, frame ticks motion is suppressed after a collision (1..255)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  vsync-rate frame strobe, asynchronous to Clk, level of any duration
keycode  in  8  0x4F right, 0x50 left, 0x51 down, 0x52 up; any other value (incl. 0x00) = stop
collision  in  1  sprite overlap flag, sampled only at frame tick
pos_x  out  10  sprite x position
pos_y  out  10  sprite y position
dir  out  2  last direction: 00 right, 01 left, 10 down, 11 up
moving  out  1  state == MOVE
blocked  out  1  state == BLOCKED
edge_hit  out  1  one-Clk pulse when a clamp altered the step

Behaviour:
- Reset (Reset_n low, asynchronous, no clock needed): pos_x=X_START, pos_y=Y_START, prev_x=X_START, prev_y=Y_START, dir=00, state=IDLE, hold_cnt=0, edge_hit=0, synchronizer flops=0, key_q=0x00.
- frame_clk passes through a 2-flop synchronizer, then a rising-edge detector. The tick is high for exactly one Clk.
- If frame_clk is first sampled high at edge k, the tick is high between k+1 and k+2, and the state and position update at edge k+2.
- A frame_clk held high for many cycles yields one tick.
- keycode is registered every Clk into key_q. The decode at a tick uses key_q.
- States: IDLE, MOVE, BLOCKED. All transitions happen only on a tick. Between ticks, every register holds except edge_hit, which clears.
- IDLE/MOVE, collision=1 at tick:
  - pos <= prev pos; prev is unchanged.
  - hold_cnt <= HOLD_FRAMES.
  - -> BLOCKED. dir is held. Collision has priority over the keycode.
- IDLE/MOVE, collision=0, valid key:
  - prev <= pos.
  - The axis selected by the key moves by STEP. The other axis is unchanged.
  - dir <= decoded value.
  - -> MOVE.
- IDLE/MOVE, collision=0, invalid key: -> IDLE. pos, prev and dir are held.
- BLOCKED, per tick:
  - The keycode is ignored.
  - If collision=1: hold_cnt reloads to HOLD_FRAMES. No second revert.
  - Else: hold_cnt decrements. On the tick where hold_cnt==1, it becomes 0 and the state -> IDLE.
- Arithmetic is done in 11-bit unsigned. No wrap-around.
  - Increment: if pos+STEP > MAX, then MAX and edge_hit=1.
  - Decrement: if pos < MIN+STEP, then MIN and edge_hit=1.
  - An exact landing on a bound does not pulse edge_hit.
  - A clamp while already at the bound still pulses edge_hit.
- Outputs are registered. moving and blocked decode the state register directly.

Test Plan:
1. Reset, keycode=0x4F, 3 frame_clk pulses: pos_x=326, pos_y=240, dir=00, moving=1. Each update lands 2 Clk after frame_clk is first sampled high.
2. keycode=0x4F held for 160 ticks from reset:
   - pos_x=638 after tick 159, with edge_hit=0.
   - Tick 160: pos_x=639 and edge_hit pulses for 1 Clk.
   - Tick 161: pos_x stays 639 and edge_hit pulses again.
3. Two 0x4F ticks (pos_x=324), then collision=1 at the next tick:
   - pos_x=322, blocked=1.
   - Then 4 ticks with collision=0 and keycode=0x52: position unchanged, blocked=1 after ticks 1-3, state IDLE after tick 4.
   - Next tick: pos_y=238, dir=11.
4. keycode 0x50 then 0x00: pos_x=318 after the 0x50 tick. After the 0x00 tick: pos_x=318, moving=0, dir=01.
5. Assert Reset_n low mid-BLOCKED with Clk stopped: all outputs take their reset values immediately. After release, the first tick with 0x51 gives pos_y=242.
6. frame_clk held high for 50 Clk, then low: exactly one position update. A glitch-free 1-Clk-wide frame_clk pulse also gives exactly one update.
